tick_pll_reconfig_ctrl: RTL and testbench



---
 rtl/tick_pll_pkg.sv | 39 +++
 rtl/tick_pll_reconfig_ctrl_lock_sync.sv | 49 ++++
 rtl/tick_pll_reconfig_ctrl.sv | 168 ++++++++++++++++
 tb/tb_tick_pll_reconfig_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_pll_pkg.sv
// Shared definitions for the tick PLL reconfiguration controller:
// reconfig-core register map, controller states and counter-word packing.
package tick_pll_pkg;

  localparam logic [5:0] ADDR_MODE   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] ADDR_START  = 6'h02;
  localparam logic [5:0] ADDR_M      = 6'h04;
  localparam logic [5:0] ADDR_C      = 6'h05;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_MODE,
    S_WR_M,
    S_WR_C,
    S_WR_START,
    S_RD_STATUS,
    S_POLL_GAP,
    S_LOCK_WAIT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [7:0] m_hi;
    logic [7:0] m_lo;
    logic       m_odd;
    logic [7:0] c_hi;
    logic [7:0] c_lo;
    logic       c_odd;
  } req_t;

  function automatic logic [17:0] pack_ctr(input logic       odd,
                                           input logic       bypass,
                                           input logic [7:0] hi,
                                           input logic [7:0] lo);
    return {odd, bypass, hi, lo};
  endfunction

endpackage

// File: rtl/tick_pll_reconfig_ctrl_lock_sync.sv
// pll_locked synchroniser plus consecutive-high counter; stable asserts
// once the synchronised lock has been high for LOCK_STABLE cycles.
module tick_lock_sync #(
  parameter int unsigned LOCK_STABLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pll_locked,
  output logic stable
);
  import tick_pll_pkg::*;

  localparam int unsigned CW = $clog2(LOCK_STABLE + 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Held cleared outside the lock wait so a lock seen before the
  // reconfiguration can never count towards the new one.
  always_comb begin
    meta_d = 1'b0;
    sync_d = 1'b0;
    cnt_d  = '0;
    if (en) begin
      meta_d = pll_locked;
      sync_d = meta_q;
      if (!sync_q)                   cnt_d = '0;
      else if (cnt_q != CW'(LOCK_STABLE)) cnt_d = cnt_q + CW'(1);
      else                           cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stable = (cnt_q == CW'(LOCK_STABLE));

endmodule

// File: rtl/tick_pll_reconfig_ctrl.sv
// Drives the PLL reconfig core's Avalon-MM port to load new M/C0 dividers,
// polls for completion and waits for a stable re-lock.
module tick_pll_reconfig_ctrl #(
  parameter int unsigned POLL_TIMEOUT = 4096,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned C_INDEX      = 0
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_m_hi,
  input  logic [7:0]  req_m_lo,
  input  logic        req_m_odd,
  input  logic [7:0]  req_c_hi,
  input  logic [7:0]  req_c_lo,
  input  logic        req_c_odd,
  output logic        done_valid,
  output logic        done_err,
  output logic        busy,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_read,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);
  import tick_pll_pkg::*;

  localparam int unsigned PW = $clog2(POLL_TIMEOUT + 1);
  localparam int unsigned LW = $clog2(LOCK_TIMEOUT + 1);

  state_e        state_q, state_d;
  req_t          req_q, req_d;
  logic          err_q, err_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          stable;
  logic          unused_rd;

  assign unused_rd = ^mgmt_readdata[31:1];

  tick_lock_sync #(.LOCK_STABLE(LOCK_STABLE)) u_lock_sync (
    .clk        (refclk),
    .rst        (rst),
    .en         (state_q == S_LOCK_WAIT),
    .pll_locked (pll_locked),
    .stable     (stable)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    err_d   = err_q;
    poll_d  = poll_q;
    lock_d  = lock_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_d   = '{m_hi: req_m_hi, m_lo: req_m_lo, m_odd: req_m_odd,
                      c_hi: req_c_hi, c_lo: req_c_lo, c_odd: req_c_odd};
          err_d   = 1'b0;
          state_d = S_WR_MODE;
        end
      end
      S_WR_MODE:  if (!mgmt_waitrequest) state_d = S_WR_M;
      S_WR_M:     if (!mgmt_waitrequest) state_d = S_WR_C;
      S_WR_C:     if (!mgmt_waitrequest) state_d = S_WR_START;
      S_WR_START: begin
        if (!mgmt_waitrequest) begin
          poll_d  = '0;
          state_d = S_RD_STATUS;
        end
      end
      S_RD_STATUS: begin
        poll_d = (poll_q == PW'(POLL_TIMEOUT)) ? poll_q : poll_q + PW'(1);
        // A completed read reporting done wins over a coincident timeout.
        if (!mgmt_waitrequest && mgmt_readdata[0]) begin
          lock_d  = '0;
          state_d = S_LOCK_WAIT;
        end else if (poll_q >= PW'(POLL_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (!mgmt_waitrequest) begin
          state_d = S_POLL_GAP;
        end
      end
      S_POLL_GAP: begin
        poll_d = (poll_q == PW'(POLL_TIMEOUT)) ? poll_q : poll_q + PW'(1);
        if (poll_q >= PW'(POLL_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RD_STATUS;
        end
      end
      S_LOCK_WAIT: begin
        lock_d = (lock_q == LW'(LOCK_TIMEOUT)) ? lock_q : lock_q + LW'(1);
        if (stable) begin
          state_d = S_DONE;
        end else if (lock_q >= LW'(LOCK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
      poll_q  <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      err_q   <= err_d;
      poll_q  <= poll_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    mgmt_address   = '0;
    mgmt_write     = 1'b0;
    mgmt_read      = 1'b0;
    mgmt_writedata = '0;
    case (state_q)
      S_WR_MODE: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_MODE;
        mgmt_writedata = 32'd1;
      end
      S_WR_M: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_M;
        mgmt_writedata = {14'b0, pack_ctr(req_q.m_odd, 1'b0, req_q.m_hi, req_q.m_lo)};
      end
      S_WR_C: begin
        mgmt_write     = 1'b1;
        mgmt_address   = ADDR_C;
        mgmt_writedata = {9'b0, 5'(C_INDEX),
                          pack_ctr(req_q.c_odd, 1'b0, req_q.c_hi, req_q.c_lo)};
      end
      S_WR_START: begin
        mgmt_write   = 1'b1;
        mgmt_address = ADDR_START;
      end
      S_RD_STATUS: begin
        mgmt_read    = 1'b1;
        mgmt_address = ADDR_STATUS;
      end
      default: ;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign done_valid = (state_q == S_DONE);
  assign done_err   = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_tick_pll_reconfig_ctrl.sv
// Bench for tick_pll_reconfig_ctrl: transaction-level reference model checked
// every cycle, directed timing scenarios with literal expectations, random soak.
module tb_tick_pll_reconfig_ctrl;

  localparam int TB_POLL    = 32;
  localparam int TB_LOCK_TO = 200;
  localparam int TB_STABLE  = 16;
  localparam int TB_CIDX    = 0;

  localparam int PH_IDLE = 0, PH_WRITE = 1, PH_POLL = 2, PH_LOCK = 3, PH_DONE = 4;

  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_m_hi = '0, req_m_lo = '0, req_c_hi = '0, req_c_lo = '0;
  logic        req_m_odd = 1'b0, req_c_odd = 1'b0;
  logic        done_valid, done_err, busy;
  logic [5:0]  mgmt_address;
  logic        mgmt_read, mgmt_write;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata = 32'h1;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b1;

  tick_pll_reconfig_ctrl #(
    .POLL_TIMEOUT (TB_POLL),
    .LOCK_TIMEOUT (TB_LOCK_TO),
    .LOCK_STABLE  (TB_STABLE),
    .C_INDEX      (TB_CIDX)
  ) dut (
    .refclk           (refclk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_m_hi         (req_m_hi),
    .req_m_lo         (req_m_lo),
    .req_m_odd        (req_m_odd),
    .req_c_hi         (req_c_hi),
    .req_c_lo         (req_c_lo),
    .req_c_odd        (req_c_odd),
    .done_valid       (done_valid),
    .done_err         (done_err),
    .busy             (busy),
    .mgmt_address     (mgmt_address),
    .mgmt_read        (mgmt_read),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_locked       (pll_locked)
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          m_phase = PH_IDLE;
  int          m_step, m_j, m_k;
  bit          m_gap, m_err, m_live = 0;
  logic [5:0]  m_waddr [4];
  logic [31:0] m_wdata [4];
  bit          m_hist [$];

  // Lock counts once the raw input was high for TB_STABLE consecutive samples,
  // seen two samples late through the synchroniser.
  function automatic bit lock_ok(input int k);
    if (k < TB_STABLE + 2) return 1'b0;
    for (int i = k - 2 - TB_STABLE; i <= k - 3; i++)
      if (!m_hist[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge refclk) begin
    cyc++;
    if (rst) begin
      m_phase = PH_IDLE;
      m_err   = 0;
      m_live  = 1;
      m_hist.delete();
    end else begin
      case (m_phase)
        PH_IDLE: if (req_valid) begin
          m_waddr[0] = 6'd0; m_wdata[0] = 32'd1;
          m_waddr[1] = 6'd4;
          m_wdata[1] = 32'(req_m_odd) * 32'h20000 + 32'(req_m_hi) * 256 + 32'(req_m_lo);
          m_waddr[2] = 6'd5;
          m_wdata[2] = 32'(TB_CIDX) * 32'h40000 + 32'(req_c_odd) * 32'h20000
                       + 32'(req_c_hi) * 256 + 32'(req_c_lo);
          m_waddr[3] = 6'd2; m_wdata[3] = 32'd0;
          m_step = 0; m_err = 0; m_phase = PH_WRITE;
        end
        PH_WRITE: if (!mgmt_waitrequest) begin
          if (m_step == 3) begin m_phase = PH_POLL; m_j = 0; m_gap = 0; end
          else m_step++;
        end
        PH_POLL: begin
          if (!m_gap && !mgmt_waitrequest && mgmt_readdata[0]) begin
            m_phase = PH_LOCK; m_k = 0; m_hist.delete();
          end else if (m_j + 1 >= TB_POLL) begin
            m_phase = PH_DONE; m_err = 1;
          end else if (m_gap) m_gap = 0;
          else if (!mgmt_waitrequest) m_gap = 1;
          m_j++;
        end
        PH_LOCK: begin
          if (lock_ok(m_k)) m_phase = PH_DONE;
          else if (m_k + 1 >= TB_LOCK_TO) begin m_phase = PH_DONE; m_err = 1; end
          m_hist.push_back(pll_locked);
          m_k++;
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare + event logging ----------------
  int          done_cnt = 0, done_cyc = 0, rd_cycles = 0;
  logic        done_err_seen;
  logic [37:0] wr_done_q [$];
  logic [37:0] wr_cyc_q  [$];

  always @(negedge refclk) begin
    if (m_live) begin
      logic       e_wr, e_rd;
      logic [5:0] e_addr;
      e_wr   = (m_phase == PH_WRITE);
      e_rd   = (m_phase == PH_POLL) && !m_gap;
      e_addr = e_wr ? m_waddr[m_step] : (e_rd ? 6'd1 : 6'd0);
      chk("req_ready",  32'(req_ready),  32'(m_phase == PH_IDLE));
      chk("busy",       32'(busy),       32'(m_phase != PH_IDLE));
      chk("done_valid", 32'(done_valid), 32'(m_phase == PH_DONE));
      chk("done_err",   32'(done_err),   32'(m_phase == PH_DONE && m_err));
      chk("mgmt_write", 32'(mgmt_write), 32'(e_wr));
      chk("mgmt_read",  32'(mgmt_read),  32'(e_rd));
      chk("mgmt_addr",  32'(mgmt_address), 32'(e_addr));
      chk("mgmt_wdata", mgmt_writedata, e_wr ? m_wdata[m_step] : 32'd0);
    end
    if (done_valid === 1'b1) begin
      done_cnt++;
      done_cyc      = cyc;
      done_err_seen = done_err;
    end
    if (mgmt_write === 1'b1) begin
      wr_cyc_q.push_back({mgmt_address, mgmt_writedata});
      if (!mgmt_waitrequest) wr_done_q.push_back({mgmt_address, mgmt_writedata});
    end
    if (mgmt_read === 1'b1) rd_cycles++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic issue(input logic [7:0] mh, input logic [7:0] ml, input logic mo,
                       input logic [7:0] ch, input logic [7:0] cl, input logic co,
                       output int e0);
    req_m_hi = mh; req_m_lo = ml; req_m_odd = mo;
    req_c_hi = ch; req_c_lo = cl; req_c_odd = co;
    req_valid = 1'b1;
    tick();
    e0 = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc, output logic derr);
    int start;
    start = done_cnt;
    dcyc  = -1;
    derr  = 1'bx;
    for (int i = 0; i < budget && done_cnt == start; i++) tick();
    if (done_cnt == start) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done_valid within %0d cycles", budget);
    end else begin
      dcyc = done_cyc;
      derr = done_err_seen;
    end
  endtask

  initial begin
    int   e0, dcyc, d0, cnt;
    logic derr;
    bit   same;

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_strobes",   32'({mgmt_write, mgmt_read, done_valid, done_err}), 32'd0);
    chk("rst_addr_data", 32'(mgmt_address) | mgmt_writedata, 32'd0);

    // S1: nominal sequence, pinned write contents and completion timing
    wr_done_q.delete();
    issue(8'd3, 8'd3, 1'b0, 8'd2, 8'd1, 1'b1, e0);
    wait_done(100, dcyc, derr);
    chk("s1_done_edge", 32'(dcyc - e0), 32'd24);
    chk("s1_done_err",  32'(derr), 32'd0);
    chk("s1_nwrites",   32'(wr_done_q.size()), 32'd4);
    if (wr_done_q.size() == 4) begin
      chk("s1_wr0", 32'(wr_done_q[0][37:32]), 32'h0); chk("s1_d0", wr_done_q[0][31:0], 32'h1);
      chk("s1_wr1", 32'(wr_done_q[1][37:32]), 32'h4); chk("s1_d1", wr_done_q[1][31:0], 32'h0000_0303);
      chk("s1_wr2", 32'(wr_done_q[2][37:32]), 32'h5); chk("s1_d2", wr_done_q[2][31:0], 32'h0002_0201);
      chk("s1_wr3", 32'(wr_done_q[3][37:32]), 32'h2); chk("s1_d3", wr_done_q[3][31:0], 32'h0);
    end

    // S2: three waitrequest cycles during the C write
    wr_cyc_q.delete();
    issue(8'd3, 8'd3, 1'b0, 8'd2, 8'd1, 1'b1, e0);
    tick(); tick();
    mgmt_waitrequest = 1'b1;
    repeat (3) tick();
    mgmt_waitrequest = 1'b0;
    wait_done(100, dcyc, derr);
    chk("s2_done_edge", 32'(dcyc - e0), 32'd27);
    cnt = 0; same = 1;
    foreach (wr_cyc_q[i])
      if (wr_cyc_q[i][37:32] == 6'd5) begin
        cnt++;
        if (wr_cyc_q[i][31:0] != 32'h0002_0201) same = 0;
      end
    chk("s2_wrc_cycles", 32'(cnt), 32'd4);
    chk("s2_wrc_stable", 32'(same), 32'd1);

    // S3: status never done -> poll timeout
    mgmt_readdata = 32'h0;
    rd_cycles = 0;
    issue(8'd10, 8'd9, 1'b1, 8'd4, 8'd4, 1'b0, e0);
    wait_done(100, dcyc, derr);
    chk("s3_done_edge", 32'(dcyc - e0), 32'd36);
    chk("s3_done_err",  32'(derr), 32'd1);
    chk("s3_reads",     32'(rd_cycles), 32'd16);

    // S4: lock drops at relative edges 10,20,30, then stays high
    mgmt_readdata = 32'h1;
    issue(8'd5, 8'd6, 1'b0, 8'd7, 8'd8, 1'b0, e0);
    d0 = done_cnt;
    for (int i = 0; i < 150 && done_cnt == d0; i++) begin
      int rel;
      rel = cyc + 1 - e0;
      pll_locked = !(rel == 10 || rel == 20 || rel == 30);
      tick();
    end
    pll_locked = 1'b1;
    chk("s4_done_seen", 32'(done_cnt - d0), 32'd1);
    chk("s4_done_edge", 32'(done_cyc - e0), 32'd49);
    chk("s4_done_err",  32'(done_err_seen), 32'd0);

    // S5: reset while reading status
    mgmt_readdata = 32'h0;
    issue(8'd1, 8'd2, 1'b0, 8'd3, 8'd4, 1'b0, e0);
    repeat (6) tick();
    chk("s5_in_read", 32'(mgmt_read), 32'd1);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_read_low",  32'(mgmt_read), 32'd0);
    chk("s5_busy_low",  32'(busy), 32'd0);
    chk("s5_ready",     32'(req_ready), 32'd1);
    repeat (6) tick();
    chk("s5_no_done",   32'(done_cnt - d0), 32'd0);
    mgmt_readdata = 32'h1;
    issue(8'd3, 8'd3, 1'b0, 8'd2, 8'd1, 1'b1, e0);
    wait_done(100, dcyc, derr);
    chk("s5_rerun_edge", 32'(dcyc - e0), 32'd24);
    chk("s5_rerun_err",  32'(derr), 32'd0);

    // S6: lock never arrives -> lock timeout
    pll_locked = 1'b0;
    issue(8'd9, 8'd9, 1'b1, 8'd9, 8'd9, 1'b1, e0);
    wait_done(400, dcyc, derr);
    chk("s6_done_edge", 32'(dcyc - e0), 32'd205);
    chk("s6_done_err",  32'(derr), 32'd1);
    pll_locked = 1'b1;

    // Random soak against the model
    for (int c = 0; c < 4000; c++) begin
      req_valid        = ($urandom_range(0, 3) == 0);
      req_m_hi         = 8'($urandom); req_m_lo = 8'($urandom); req_m_odd = 1'($urandom);
      req_c_hi         = 8'($urandom); req_c_lo = 8'($urandom); req_c_odd = 1'($urandom);
      mgmt_waitrequest = ($urandom_range(0, 3) == 0);
      mgmt_readdata    = $urandom;
      mgmt_readdata[0] = ($urandom_range(0, 3) == 0);
      pll_locked       = ($urandom_range(0, 24) != 0);
      rst              = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    req_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
